// File: rtl/axis_pkt_fifo_if.sv
// AXI4-Stream bundle used on both sides of axis_pkt_fifo.
// The master modport drives the beat; the slave modport drives tready.
interface axis_pkt_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    localparam int KEEP_W = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_W-1:0]     tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream synchronous FIFO with first-word fall-through output, occupancy count
// and an optional store-and-forward mode that drops packets larger than the buffer.
module axis_pkt_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16,
    parameter int PKT_MODE   = 0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axis_pkt_fifo_if.slave         s_axis,
    axis_pkt_fifo_if.master        m_axis,
    output logic [$clog2(DEPTH):0] fill_count,
    output logic                   drop_pulse
);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int KEEP_W  = DATA_WIDTH / 8;
    localparam int ENTRY_W = USER_WIDTH + 1 + KEEP_W + DATA_WIDTH;
    localparam bit PKT_EN  = (PKT_MODE != 0);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W + 1){1'b0}};

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   wr_cur_q, wr_cur_d;
    logic              live_q;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]    fill_s;
    logic               full_s;
    logic               empty_s;
    logic               tready_s;
    logic               wr_hs_s;
    logic               rd_hs_s;
    logic               wr_en_s;
    logic               drop_s;
    logic [ENTRY_W-1:0] wr_entry_s;
    logic [ENTRY_W-1:0] rd_entry_s;

    // Occupancy, handshakes and the write-side ready decision.
    always_comb begin
        fill_s  = wr_cur_q - rd_ptr_q;
        full_s  = (fill_s == DEPTH_C);
        empty_s = (rd_ptr_q == wr_ptr_q);
        // live_q keeps tready low until the first edge after reset release.
        if (!live_q) begin
            tready_s = 1'b0;
        end else if (PKT_EN && (state_q == ST_DROP)) begin
            tready_s = 1'b1;
        end else begin
            tready_s = !full_s;
        end
        wr_hs_s    = s_axis.tvalid && tready_s;
        rd_hs_s    = !empty_s && m_axis.tready;
        wr_en_s    = wr_hs_s && (state_q == ST_ACCEPT);
        drop_s     = PKT_EN && wr_hs_s && (state_q == ST_DROP) && s_axis.tlast;
        wr_entry_s = {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        rd_entry_s = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end

    // Next-state for pointers and the accept/drop FSM.
    always_comb begin
        rd_ptr_d = rd_ptr_q + (rd_hs_s ? ONE_C : ZERO_C);
        wr_cur_d = wr_cur_q;
        wr_ptr_d = wr_ptr_q;
        state_d  = state_q;
        if (wr_en_s) begin
            wr_cur_d = wr_cur_q + ONE_C;
            if (!PKT_EN || s_axis.tlast) begin
                wr_ptr_d = wr_cur_q + ONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
        end else begin
            wr_cur_d = wr_cur_q;
        end
        case (state_q)
            ST_ACCEPT: begin
                // A partial packet that alone fills the buffer can never commit: rewind and drop it.
                if (PKT_EN && full_s && (wr_ptr_q == rd_ptr_q)) begin
                    state_d  = ST_DROP;
                    wr_cur_d = wr_ptr_q;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_DROP: begin
                if (drop_s) begin
                    state_d = ST_ACCEPT;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_ACCEPT;
            rd_ptr_q <= ZERO_C;
            wr_ptr_q <= ZERO_C;
            wr_cur_q <= ZERO_C;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            wr_cur_q <= wr_cur_d;
            live_q   <= 1'b1;
        end
    end

    // Beat storage; contents are don't-care until a pointer exposes them.
    always_ff @(posedge aclk) begin
        if (wr_en_s) begin
            mem_q[wr_cur_q[ADDR_W-1:0]] <= wr_entry_s;
        end
    end

    assign s_axis.tready = tready_s;
    assign m_axis.tvalid = !empty_s;
    assign {m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = rd_entry_s;
    assign fill_count    = fill_s;
    assign drop_pulse    = drop_s;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo: one cut-through and one store-and-forward instance.
module tb_axis_pkt_fifo;
    logic clk;
    logic rst_n;
    int   total_cnt;
    int   bad_cnt;

    logic [10:0] exp0_q[$];
    logic [10:0] exp1_q[$];

    axis_pkt_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s0_if ();
    axis_pkt_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m0_if ();
    axis_pkt_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s1_if ();
    axis_pkt_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m1_if ();

    logic [4:0] fc0;
    logic [4:0] fc1;
    logic       dp0;
    logic       dp1;

    axis_pkt_fifo #(.DATA_WIDTH(8), .USER_WIDTH(1), .DEPTH(16), .PKT_MODE(0)) u_dut0 (
        .aclk(clk), .aresetn(rst_n), .s_axis(s0_if), .m_axis(m0_if),
        .fill_count(fc0), .drop_pulse(dp0)
    );

    axis_pkt_fifo #(.DATA_WIDTH(8), .USER_WIDTH(1), .DEPTH(16), .PKT_MODE(1)) u_dut1 (
        .aclk(clk), .aresetn(rst_n), .s_axis(s1_if), .m_axis(m1_if),
        .fill_count(fc1), .drop_pulse(dp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic k, input logic l, input logic u);
        return {u, l, k, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Output monitors: compare each beat that will be consumed at the next rising edge.
    always @(negedge clk) begin
        check_val("d0_drop_zero", {31'd0, dp0}, 32'd0);
        if (m0_if.tvalid && m0_if.tready) begin
            if (exp0_q.size() == 0) begin
                check_val("d0_extra_beat", {21'd0, m0_if.tuser, m0_if.tlast, m0_if.tkeep, m0_if.tdata}, 32'hFFFF_FFFF);
            end else begin
                check_val("d0_beat", {21'd0, m0_if.tuser, m0_if.tlast, m0_if.tkeep, m0_if.tdata}, {21'd0, exp0_q.pop_front()});
            end
        end
        if (m1_if.tvalid && m1_if.tready) begin
            if (exp1_q.size() == 0) begin
                check_val("d1_extra_beat", {21'd0, m1_if.tuser, m1_if.tlast, m1_if.tkeep, m1_if.tdata}, 32'hFFFF_FFFF);
            end else begin
                check_val("d1_beat", {21'd0, m1_if.tuser, m1_if.tlast, m1_if.tkeep, m1_if.tdata}, {21'd0, exp1_q.pop_front()});
            end
        end
    end

    task automatic drive(input bit sel, input logic [10:0] e);
        if (sel) begin
            {s1_if.tuser, s1_if.tlast, s1_if.tkeep, s1_if.tdata} = e;
            s1_if.tvalid = 1'b1;
        end else begin
            {s0_if.tuser, s0_if.tlast, s0_if.tkeep, s0_if.tdata} = e;
            s0_if.tvalid = 1'b1;
        end
    endtask

    task automatic send(input bit sel, input logic [10:0] e, input bit push);
        logic rdy;
        int   n;
        n = 0;
        drive(sel, e);
        forever begin
            @(negedge clk);
            rdy = sel ? s1_if.tready : s0_if.tready;
            tick();
            if (rdy) break;
            n++;
            if (n > 50) begin
                check_val("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        if (rdy && push) begin
            if (sel) exp1_q.push_back(e);
            else     exp0_q.push_back(e);
        end
        s0_if.tvalid = 1'b0;
        s1_if.tvalid = 1'b0;
    endtask

    task automatic drain(input bit sel);
        for (int k = 0; k < 40; k++) begin
            if ((sel ? exp1_q.size() : exp0_q.size()) == 0) break;
            tick();
        end
        check_val(sel ? "d1_drain_q" : "d0_drain_q", sel ? exp1_q.size() : exp0_q.size(), 32'd0);
        @(negedge clk);
        check_val(sel ? "d1_drain_fc" : "d0_drain_fc", {27'd0, sel ? fc1 : fc0}, 32'd0);
        check_val(sel ? "d1_drain_tv" : "d0_drain_tv", {31'd0, sel ? m1_if.tvalid : m0_if.tvalid}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n = 1'b0;
        s0_if.tvalid = 1'b0; s0_if.tdata = 8'h00; s0_if.tkeep = 1'b0; s0_if.tlast = 1'b0; s0_if.tuser = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = 8'h00; s1_if.tkeep = 1'b0; s1_if.tlast = 1'b0; s1_if.tuser = 1'b0;
        m0_if.tready = 1'b0;
        m1_if.tready = 1'b0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check_val("rst_tv0", {31'd0, m0_if.tvalid}, 32'd0);
        check_val("rst_tr0", {31'd0, s0_if.tready}, 32'd0);
        check_val("rst_fc0", {27'd0, fc0}, 32'd0);
        check_val("rst_tv1", {31'd0, m1_if.tvalid}, 32'd0);
        check_val("rst_tr1", {31'd0, s1_if.tready}, 32'd0);
        check_val("rst_fc1", {27'd0, fc1}, 32'd0);
        check_val("rst_dp1", {31'd0, dp1}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: fill cut-through FIFO with output stalled, then drain
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, mk(8'(i), 1'(i % 2), 1'b0, 1'(i / 2 % 2)));
            @(negedge clk);
            check_val("t1_tready", {31'd0, s0_if.tready}, (i <= 16) ? 32'd1 : 32'd0);
            check_val("t1_fill", {27'd0, fc0}, (i <= 16) ? 32'(i - 1) : 32'd16);
            if (i <= 16) exp0_q.push_back(mk(8'(i), 1'(i % 2), 1'b0, 1'(i / 2 % 2)));
            tick();
        end
        s0_if.tvalid = 1'b0;
        @(negedge clk);
        check_val("t1_full_fc", {27'd0, fc0}, 32'd16);
        check_val("t1_full_tr", {31'd0, s0_if.tready}, 32'd0);
        tick();
        m0_if.tready = 1'b1;
        drain(1'b0);

        // Test 2: streaming through at one beat per cycle
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, mk(8'(8'h40 + i), 1'b1, 1'(i % 3 == 0), 1'(i % 2)));
            @(negedge clk);
            check_val("t2_tready", {31'd0, s0_if.tready}, 32'd1);
            check_val("t2_tvalid", {31'd0, m0_if.tvalid}, (i == 0) ? 32'd0 : 32'd1);
            check_val("t2_fill", {27'd0, fc0}, (i == 0) ? 32'd0 : 32'd1);
            exp0_q.push_back(mk(8'(8'h40 + i), 1'b1, 1'(i % 3 == 0), 1'(i % 2)));
            tick();
        end
        s0_if.tvalid = 1'b0;
        drain(1'b0);

        // Test 3: packet held invisible until its last beat commits
        m1_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk(8'(8'hA0 + i), 1'(i % 2), 1'(i == 4), 1'(i == 2)));
            @(negedge clk);
            check_val("t3_tready", {31'd0, s1_if.tready}, 32'd1);
            check_val("t3_hidden", {31'd0, m1_if.tvalid}, 32'd0);
            exp1_q.push_back(mk(8'(8'hA0 + i), 1'(i % 2), 1'(i == 4), 1'(i == 2)));
            tick();
        end
        s1_if.tvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("t3_burst_tv", {31'd0, m1_if.tvalid}, 32'd1);
            tick();
        end
        drain(1'b1);

        // Test 4: oversize packet dropped, then a short packet passes
        m1_if.tready = 1'b0;
        begin
            int b;
            b = 1;
            for (int c = 0; c <= 20; c++) begin
                if (b <= 20) drive(1'b1, mk(8'(8'hB0 + b), 1'b1, 1'(b == 20), 1'b0));
                else s1_if.tvalid = 1'b0;
                @(negedge clk);
                check_val("t4_tready", {31'd0, s1_if.tready}, (c == 16) ? 32'd0 : 32'd1);
                check_val("t4_fill", {27'd0, fc1}, (c <= 16) ? 32'(c) : 32'd0);
                check_val("t4_drop", {31'd0, dp1}, (c == 20) ? 32'd1 : 32'd0);
                check_val("t4_tvalid", {31'd0, m1_if.tvalid}, 32'd0);
                if (s1_if.tready) b++;
                tick();
            end
            check_val("t4_beats", 32'(b), 32'd21);
        end
        s1_if.tvalid = 1'b0;
        @(negedge clk);
        check_val("t4_after_dp", {31'd0, dp1}, 32'd0);
        check_val("t4_after_fc", {27'd0, fc1}, 32'd0);
        tick();
        m1_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b1, mk(8'(8'hC0 + i), 1'b1, 1'(i == 2), 1'(i == 1)), 1'b1);
        drain(1'b1);

        // Test 5: back-pressure at full with committed data ahead, no drop
        m1_if.tready = 1'b0;
        for (int i = 0; i < 10; i++) send(1'b1, mk(8'(8'h10 + i), 1'(i % 2), 1'(i == 9), 1'(i % 3 == 0)), 1'b1);
        @(negedge clk);
        check_val("t5_p1_fc", {27'd0, fc1}, 32'd10);
        check_val("t5_p1_tv", {31'd0, m1_if.tvalid}, 32'd1);
        tick();
        for (int i = 0; i < 6; i++) send(1'b1, mk(8'(8'h60 + i), 1'(i % 2 == 0), 1'b0, 1'(i % 2)), 1'b1);
        drive(1'b1, mk(8'h66, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("t5_stall_tr", {31'd0, s1_if.tready}, 32'd0);
            check_val("t5_stall_fc", {27'd0, fc1}, 32'd16);
            check_val("t5_stall_dp", {31'd0, dp1}, 32'd0);
            tick();
        end
        m1_if.tready = 1'b1;
        for (int i = 6; i < 10; i++) send(1'b1, mk(8'(8'h60 + i), 1'(i % 2 == 0), 1'(i == 9), 1'(i % 2)), 1'b1);
        drain(1'b1);

        // Test 6: reset mid-packet discards everything
        m1_if.tready = 1'b0;
        for (int i = 0; i < 7; i++) send(1'b1, mk(8'(8'h70 + i), 1'b1, 1'b0, 1'b0), 1'b0);
        @(negedge clk);
        check_val("t6_pre_fc", {27'd0, fc1}, 32'd7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_tv", {31'd0, m1_if.tvalid}, 32'd0);
        check_val("t6_rst_tr", {31'd0, s1_if.tready}, 32'd0);
        check_val("t6_rst_fc", {27'd0, fc1}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        m1_if.tready = 1'b1;
        m0_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b1, mk(8'(8'hD0 + i), 1'(i % 2), 1'(i == 2), 1'b1), 1'b1);
        drain(1'b1);
        for (int i = 0; i < 2; i++) send(1'b0, mk(8'(8'hE0 + i), 1'b1, 1'(i == 1), 1'(i % 2)), 1'b1);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
